// File: rtl/game_round_sequencer.sv
// Phase controller for the symbol-counting game.
// Runs NUM_ROUNDS rounds of GEN -> WAIT_GEN -> ANSWER -> CHECK (-> GAP), then
// stays in OVER until a new start edge. It owns the round number, the score
// and the seconds-remaining value shown on the display.
// Ports:
//   Clk100M, nReset          clock, async active-low reset
//   tick1Hz                  one-cycle pulse once per second
//   startBtn                 debounced start level (rising edge used)
//   genDone, trueCount       generator completion pulse and its count
//   userCount                player's count, sampled in CHECK
//   startGen, stopGen        one-cycle generator control pulses
//   answerOpen               high for the whole ANSWER phase
//   secondsLeft              countdown in GEN/ANSWER, 0 elsewhere
//   round, score, correct    game progress and scoring pulse
//   phase, gameOver          current state and end-of-game level
module game_round_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 5,
  parameter int unsigned GEN_SECONDS    = 4,
  parameter int unsigned ANSWER_SECONDS = 5,
  parameter int unsigned GEN_TIMEOUT    = 2
) (
  input  logic       Clk100M,
  input  logic       nReset,
  input  logic       tick1Hz,
  input  logic       startBtn,
  input  logic       genDone,
  input  logic [7:0] trueCount,
  input  logic [7:0] userCount,
  output logic       startGen,
  output logic       stopGen,
  output logic       answerOpen,
  output logic [3:0] secondsLeft,
  output logic [3:0] round,
  output logic [7:0] score,
  output logic       correct,
  output logic [2:0] phase,
  output logic       gameOver
);

  localparam int unsigned CW = 8;  // count / score width
  localparam int unsigned SW = 4;  // seconds and timeout counter width
  localparam int unsigned RW = 4;  // round width

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_WAIT_GEN = 3'd2,
    S_ANSWER   = 3'd3,
    S_CHECK    = 3'd4,
    S_GAP      = 3'd5,
    S_OVER     = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   round_q, round_d;
  logic [CW-1:0]   score_q, score_d;
  logic [SW-1:0]   secs_q, secs_d;
  logic [SW-1:0]   to_cnt_q, to_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_seen_q, done_seen_d;
  logic            start_gen_q, start_gen_d;
  logic            stop_gen_q, stop_gen_d;
  logic            answer_open_q, answer_open_d;
  logic            correct_q, correct_d;
  logic            game_over_q, game_over_d;
  logic            btn_q;
  logic            start_edge;

  assign start_edge = startBtn & ~btn_q;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    score_d       = score_q;
    secs_d        = secs_q;
    to_cnt_d      = to_cnt_q;
    count_d       = count_q;
    done_seen_d   = done_seen_q;
    answer_open_d = answer_open_q;
    game_over_d   = game_over_q;
    start_gen_d   = 1'b0;
    stop_gen_d    = 1'b0;
    correct_d     = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        // A tick in the same cycle is simply dropped: GEN starts full length.
        if (start_edge) begin
          state_d     = S_GEN;
          round_d     = RW'(1);
          score_d     = '0;
          game_over_d = 1'b0;
          secs_d      = SW'(GEN_SECONDS);
          start_gen_d = 1'b1;
          done_seen_d = 1'b0;
        end
      end
      S_GEN: begin
        // An early genDone is remembered but does not shorten the phase.
        if (genDone) begin
          count_d     = trueCount;
          done_seen_d = 1'b1;
        end
        if (tick1Hz) begin
          if (secs_q == SW'(1)) begin
            secs_d     = '0;
            stop_gen_d = 1'b1;
            to_cnt_d   = '0;
            state_d    = S_WAIT_GEN;
          end else begin
            secs_d = secs_q - SW'(1);
          end
        end
      end
      S_WAIT_GEN: begin
        if (genDone || done_seen_q || (tick1Hz && to_cnt_q == SW'(GEN_TIMEOUT - 1))) begin
          if (genDone) begin
            count_d = trueCount;
          end else if (!done_seen_q) begin
            count_d = '0;  // generator never answered
          end
          state_d       = S_ANSWER;
          answer_open_d = 1'b1;
          secs_d        = SW'(ANSWER_SECONDS);
        end else if (tick1Hz) begin
          to_cnt_d = to_cnt_q + SW'(1);
        end
      end
      S_ANSWER: begin
        if (tick1Hz) begin
          if (secs_q == SW'(1)) begin
            secs_d        = '0;
            answer_open_d = 1'b0;
            state_d       = S_CHECK;
          end else begin
            secs_d = secs_q - SW'(1);
          end
        end
      end
      S_CHECK: begin
        if (userCount == count_q) begin
          correct_d = 1'b1;
          if (score_q != {CW{1'b1}}) begin
            score_d = score_q + CW'(1);
          end
        end
        if (round_q == RW'(NUM_ROUNDS)) begin
          state_d     = S_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick1Hz) begin
          state_d     = S_GEN;
          round_d     = round_q + RW'(1);
          secs_d      = SW'(GEN_SECONDS);
          start_gen_d = 1'b1;
          done_seen_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk100M or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      score_q       <= '0;
      secs_q        <= '0;
      to_cnt_q      <= '0;
      count_q       <= '0;
      done_seen_q   <= 1'b0;
      start_gen_q   <= 1'b0;
      stop_gen_q    <= 1'b0;
      answer_open_q <= 1'b0;
      correct_q     <= 1'b0;
      game_over_q   <= 1'b0;
      btn_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      score_q       <= score_d;
      secs_q        <= secs_d;
      to_cnt_q      <= to_cnt_d;
      count_q       <= count_d;
      done_seen_q   <= done_seen_d;
      start_gen_q   <= start_gen_d;
      stop_gen_q    <= stop_gen_d;
      answer_open_q <= answer_open_d;
      correct_q     <= correct_d;
      game_over_q   <= game_over_d;
      btn_q         <= startBtn;
    end
  end

  assign startGen    = start_gen_q;
  assign stopGen     = stop_gen_q;
  assign answerOpen  = answer_open_q;
  assign secondsLeft = secs_q;
  assign round       = round_q;
  assign score       = score_q;
  assign correct     = correct_q;
  assign phase       = state_q;
  assign gameOver    = game_over_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer (NUM_ROUNDS=3, other parameters default).
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       nReset, tick1Hz, startBtn, genDone;
  logic [7:0] trueCount, userCount;
  logic       startGen, stopGen, answerOpen, correct, gameOver;
  logic [3:0] secondsLeft, round;
  logic [7:0] score;
  logic [2:0] phase;

  int vectors     = 0;
  int miscompares = 0;
  int sg_count    = 0;
  int ans_ticks   = 0;

  game_round_sequencer #(
    .NUM_ROUNDS(3), .GEN_SECONDS(4), .ANSWER_SECONDS(5), .GEN_TIMEOUT(2)
  ) dut (
    .Clk100M(clk), .nReset(nReset), .tick1Hz(tick1Hz), .startBtn(startBtn),
    .genDone(genDone), .trueCount(trueCount), .userCount(userCount),
    .startGen(startGen), .stopGen(stopGen), .answerOpen(answerOpen),
    .secondsLeft(secondsLeft), .round(round), .score(score), .correct(correct),
    .phase(phase), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // Count startGen pulses and ticks seen while the answer window is open.
  always @(posedge clk) begin
    if (startGen) sg_count <= sg_count + 1;
    if (tick1Hz && answerOpen) ans_ticks <= ans_ticks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick1Hz = 1'b1;
    cyc();
    tick1Hz = 1'b0;
  endtask

  // Entered one step after the edge that moved the DUT into GEN.
  task automatic round_body(input logic [7:0] tc, input logic [7:0] uc,
                            input bit use_done, input bit poke, input bit abort,
                            input int exp_round, input int exp_score, input int exp_correct);
    int a0;
    check("gen_phase", 32'(phase), 1);
    check("gen_startGen", 32'(startGen), 1);
    check("gen_round", 32'(round), 32'(exp_round));
    check("gen_secs", 32'(secondsLeft), 4);
    cyc();
    check("startGen_single", 32'(startGen), 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      check("gen_countdown", 32'(secondsLeft), 32'(4 - i));
      check("gen_hold", 32'(phase), 1);
      cyc();
    end
    pulse_tick();
    check("waitgen_phase", 32'(phase), 2);
    check("stopGen_pulse", 32'(stopGen), 1);
    check("waitgen_secs", 32'(secondsLeft), 0);
    if (use_done) begin
      genDone = 1'b1; trueCount = tc;
      cyc();
      genDone = 1'b0; trueCount = 8'd0;
    end else begin
      cyc();
      check("stopGen_single", 32'(stopGen), 0);
      pulse_tick();
      check("timeout_wait", 32'(phase), 2);
      cyc();
      pulse_tick();
    end
    check("answer_phase", 32'(phase), 3);
    check("answer_open", 32'(answerOpen), 1);
    check("answer_secs", 32'(secondsLeft), 5);
    userCount = uc;
    a0 = ans_ticks;
    for (int i = 1; i <= 4; i++) begin
      pulse_tick();
      cyc();
      if (i == 2 && poke) begin
        startBtn = 1'b1;
        cyc();
        startBtn = 1'b0;
        cyc();
        check("poke_phase", 32'(phase), 3);
        check("poke_round", 32'(round), 32'(exp_round));
        check("poke_score", 32'(score), 32'(exp_score - exp_correct));
        check("poke_secs", 32'(secondsLeft), 3);
      end
      if (i == 2 && abort) begin
        #2 nReset = 1'b0;
        #1;
        check("rst_phase", 32'(phase), 0);
        check("rst_answerOpen", 32'(answerOpen), 0);
        check("rst_secs", 32'(secondsLeft), 0);
        check("rst_round", 32'(round), 0);
        check("rst_score", 32'(score), 0);
        return;
      end
    end
    pulse_tick();
    check("check_phase", 32'(phase), 4);
    check("answer_closed", 32'(answerOpen), 0);
    check("check_secs", 32'(secondsLeft), 0);
    check("answer_ticks", 32'(ans_ticks - a0), 5);
    cyc();
    check("correct_pulse", 32'(correct), 32'(exp_correct));
    check("score", 32'(score), 32'(exp_score));
    check("post_phase", 32'(phase), (exp_round == 3) ? 6 : 5);
    check("gameOver", 32'(gameOver), (exp_round == 3) ? 1 : 0);
    cyc();
    check("correct_single", 32'(correct), 0);
  endtask

  task automatic gap_to_gen();
    cyc(); cyc();
    check("gap_phase", 32'(phase), 5);
    check("gap_secs", 32'(secondsLeft), 0);
    pulse_tick();
  endtask

  initial begin
    nReset = 1'b0; tick1Hz = 1'b0; startBtn = 1'b0; genDone = 1'b0;
    trueCount = 8'd0; userCount = 8'd0;
    cyc(); cyc(); cyc();
    check("reset_phase", 32'(phase), 0);
    nReset = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      cyc();
    end
    check("idle_phase", 32'(phase), 0);
    check("idle_outputs", {startGen, stopGen, answerOpen, correct, gameOver,
                           secondsLeft, round, score}, 0);
    check("idle_no_startGen", 32'(sg_count), 0);

    // Game 1: correct, wrong, correct.
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    round_body(8'd7, 8'd7, 1'b1, 1'b0, 1'b0, 1, 1, 1);
    gap_to_gen();
    round_body(8'd9, 8'd3, 1'b1, 1'b0, 1'b0, 2, 1, 0);
    gap_to_gen();
    round_body(8'd4, 8'd4, 1'b1, 1'b0, 1'b0, 3, 2, 1);
    check("over_round", 32'(round), 3);
    check("over_score", 32'(score), 2);
    check("startGen_count", 32'(sg_count), 3);
    pulse_tick();
    check("over_hold", 32'(phase), 6);

    // Game 2: restart from OVER, timeout round with a stray start press.
    startBtn = 1'b1;
    cyc();
    startBtn = 1'b0;
    check("restart_score", 32'(score), 0);
    check("restart_gameOver", 32'(gameOver), 0);
    round_body(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1, 1, 1);
    gap_to_gen();
    round_body(8'd5, 8'd5, 1'b1, 1'b0, 1'b1, 2, 1, 1);
    cyc();
    nReset = 1'b1;
    cyc(); cyc();
    check("release_phase", 32'(phase), 0);
    check("release_pulses", {startGen, stopGen, correct}, 0);
    check("release_startGen_count", 32'(sg_count), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
Top-level phase controller for the symbol-counting game. It runs a fixed number of rounds. Each round has three phases: a symbol-generation phase, a timed answer phase in which the player enters a count, and a scoring check against the true count. It starts the symbol generator and opens the answer window, and it owns the round counter, the score and the seconds-remaining value shown on the 7-segment display logic.

Parameters:
NUM_ROUNDS, 5, rounds per game (1..15)
GEN_SECONDS, 4, seconds the symbol generator runs per round (1..15)
ANSWER_SECONDS, 5, seconds the answer window stays open (1..15)
GEN_TIMEOUT, 2, ticks to wait for genDone after stopGen before forcing trueCount=0 (1..15)

Ports:
Clk100M  in  1  system clock, 100 MHz
nReset  in  1  asynchronous, active-low reset
tick1Hz  in  1  one-Clk100M-cycle pulse, once per second, synchronous to Clk100M
startBtn  in  1  debounced start button level; rising edge detected internally
genDone  in  1  one-cycle pulse from generator; trueCount valid in same cycle
trueCount  in  8  number of target symbols generated this round
userCount  in  8  player's current count, sampled in CHECK
startGen  out  1  one-cycle pulse: generator begins a new sequence
stopGen  out  1  one-cycle pulse: generator must stop and report
answerOpen  out  1  level; high for the whole ANSWER phase
secondsLeft  out  4  seconds remaining in GEN or ANSWER, 0 elsewhere
round  out  4  current round, 1-based; 0 in IDLE
score  out  8  correct answers this game, saturates at 255
correct  out  1  one-cycle pulse when a round is scored correct
phase  out  3  IDLE=0, GEN=1, WAIT_GEN=2, ANSWER=3, CHECK=4, GAP=5, OVER=6
gameOver  out  1  level; high in OVER

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Latched count 0. Start edge register 0.
- Start edge is startBtn high this cycle while its registered copy is low. It is honoured only in IDLE and OVER; it is ignored in all other states.
- IDLE/OVER + start edge -> GEN next cycle. On entry to GEN: round=1, score=0, gameOver=0, secondsLeft=GEN_SECONDS, startGen pulses in the first GEN cycle.
- GEN: each tick1Hz decrements secondsLeft.
  - A tick with secondsLeft==1 sets secondsLeft=0, pulses stopGen the next cycle and moves to WAIT_GEN.
- WAIT_GEN: genDone latches trueCount -> ANSWER.
  - genDone outside GEN/WAIT_GEN is ignored. genDone during GEN is latched, but the phase still runs to full length.
  - If GEN_TIMEOUT ticks pass with no genDone, latch 0 -> ANSWER.
- ANSWER: on entry, answerOpen=1 and secondsLeft=ANSWER_SECONDS. Ticks decrement secondsLeft. A tick at 1 -> secondsLeft=0, answerOpen=0, go to CHECK.
- CHECK: exactly one cycle.
  - If userCount == latched count: correct pulses and score increments, saturating at 255.
  - Next state: if round==NUM_ROUNDS, OVER; otherwise GAP.
- GAP: the first tick increments round, pulses startGen, reloads secondsLeft=GEN_SECONDS and enters GEN. This is a 1 s gap between rounds.
- OVER: gameOver=1. round and score hold their final values for display until a start edge.
- Tick and start edge in the same cycle in IDLE/OVER: start wins; the tick is not counted toward the new GEN phase.
- All outputs are registered. phase reflects the current state with no extra latency.
- nReset asserted mid-game aborts immediately. No pulse is emitted on reset release.

Test Plan:
- Reset then idle with ticks: nReset low 3 cycles, 10 ticks, no start -> phase=0, all outputs 0, no startGen.
- Full correct round, NUM_ROUNDS=1:
  - Stimulus: start; genDone with trueCount=7 one cycle after stopGen; userCount=7.
  - Required: startGen 1 cycle after start edge, stopGen after 4th tick, answerOpen high for exactly 5 ticks, correct pulses once, score=1, gameOver=1, round=1.
- Wrong answer and multi-round:
  - Stimulus: NUM_ROUNDS=3, answers correct/wrong/correct.
  - Required: score=2, round=3 at OVER, exactly 3 startGen pulses, GAP of 1 tick between rounds.
- Generator timeout: no genDone after stopGen -> ANSWER entered after 2 ticks; userCount=0 scores correct.
- Start ignored mid-game: start pulsed during ANSWER -> no state change, round and score unchanged. Restart from OVER -> score=0, round=1.
- Async reset mid-ANSWER: nReset low between clocks -> outputs 0 before next Clk100M edge, phase=IDLE.
